// File: rtl/speech256_pkg.sv
// ============================================================================
// Module      : speech256_pkg
// Description : Shared widths, dispatcher state encoding and pause codes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package speech256_pkg;

    localparam int ALLO_W = 6;

    typedef enum logic [1:0] {
        AQ_IDLE     = 2'd0,
        AQ_STROBE   = 2'd1,
        AQ_WAIT_LOW = 2'd2
    } aq_state_t;

    // Pause allophones travel through the queue like any other code.
    localparam logic [ALLO_W-1:0] PA1 = 6'd0;
    localparam logic [ALLO_W-1:0] PA2 = 6'd1;
    localparam logic [ALLO_W-1:0] PA3 = 6'd2;
    localparam logic [ALLO_W-1:0] PA4 = 6'd3;
    localparam logic [ALLO_W-1:0] PA5 = 6'd4;

endpackage

`default_nettype wire

// File: rtl/allo_fifo.sv
// ============================================================================
// Module      : allo_fifo
// Description : Synchronous allophone FIFO with registered count and flush.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module allo_fifo
    import speech256_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [ALLO_W-1:0] push_data,
    input  logic              pop,
    output logic [ALLO_W-1:0] head,
    output logic [AW:0]       count,
    output logic              full,
    output logic              head_valid
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [ALLO_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_head_valid;
    logic              w_push;
    logic              w_pop;

    assign w_push = push && (r_count != c_depth) && !flush;
    assign w_pop  = pop && (r_count != '0) && !flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // head_valid lags count by one cycle so a fresh write never falls through.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_head_valid <= 1'b0;
        end else begin
            r_head_valid <= (r_count != '0);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head       = r_mem[r_rd_ptr];
    assign count      = r_count;
    assign full       = (r_count == c_depth);
    assign head_valid = r_head_valid;

endmodule

`default_nettype wire

// File: rtl/allophone_queue.sv
// ============================================================================
// Module      : allophone_queue
// Description : Host allophone queue and ldq-paced dispatcher for Speech256.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module allophone_queue
    import speech256_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int AW          = 3,
    parameter int STB_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ALLO_W-1:0] host_data,
    input  logic              host_wr,
    input  logic              flush,
    output logic              host_full,
    output logic [AW:0]       count,
    output logic              overflow,
    input  logic              ldq,
    output logic [ALLO_W-1:0] data_out,
    output logic              data_stb,
    output logic              busy,
    output logic              timeout
);

    localparam int c_gw = $clog2(STB_TIMEOUT + 1);
    localparam logic [c_gw-1:0] c_guard_last = c_gw'(STB_TIMEOUT - 1);

    aq_state_t         r_state;
    aq_state_t         w_state_nxt;
    logic [c_gw-1:0]   r_guard;
    logic [c_gw-1:0]   w_guard_nxt;
    logic              r_stb;
    logic              w_stb_nxt;
    logic              w_pop;
    logic              w_set_timeout;
    logic              r_overflow;
    logic              r_timeout;
    logic [ALLO_W-1:0] r_data_out;
    logic [ALLO_W-1:0] w_head;
    logic [AW:0]       w_count;
    logic              w_full;
    logic              w_head_valid;

    allo_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (host_wr),
        .push_data  (host_data),
        .pop        (w_pop),
        .head       (w_head),
        .count      (w_count),
        .full       (w_full),
        .head_valid (w_head_valid)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_guard_nxt   = r_guard;
        w_stb_nxt     = 1'b0;
        w_pop         = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            AQ_IDLE: begin
                if (ldq && w_head_valid && (w_count != '0)) begin
                    w_pop       = 1'b1;
                    w_stb_nxt   = 1'b1;
                    w_state_nxt = AQ_STROBE;
                end
            end
            AQ_STROBE: begin
                w_guard_nxt = '0;
                w_state_nxt = AQ_WAIT_LOW;
            end
            AQ_WAIT_LOW: begin
                if (!ldq) begin
                    w_state_nxt = AQ_IDLE;
                end else begin
                    w_guard_nxt = r_guard + 1'b1;
                    // A controller stuck high must not wedge the queue.
                    if (r_guard == c_guard_last) begin
                        w_set_timeout = 1'b1;
                        w_state_nxt   = AQ_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = AQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= AQ_IDLE;
            r_guard    <= '0;
            r_stb      <= 1'b0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
            r_data_out <= '0;
        end else if (flush) begin
            r_state    <= AQ_IDLE;
            r_stb      <= 1'b0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_guard <= w_guard_nxt;
            r_stb   <= w_stb_nxt;
            if (w_pop) begin
                r_data_out <= w_head;
            end
            if (host_wr && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign host_full = w_full;
    assign count     = w_count;
    assign overflow  = r_overflow;
    assign data_out  = r_data_out;
    assign data_stb  = r_stb;
    assign timeout   = r_timeout;
    assign busy      = (w_count != '0) || (r_state != AQ_IDLE);

endmodule

`default_nettype wire

// File: doc/allophone_queue.md
# allophone_queue

Host-side command queue and dispatcher for the Speech256 allophone controller. Buffers 6-bit allophone codes written by a host at arbitrary times. Issues them one at a time to the controller's `data_in`/`data_stb` port, only when the controller's `ldq` signals it can take a new allophone. Sits between the host bus and the controller so the host never has to poll `ldq` itself.

## Interface

- DEPTH, 8: FIFO entries; must be a power of two, at least 2.
- AW, 3: log2(DEPTH).
- STB_TIMEOUT, 15: cycles to wait for `ldq` to drop after a strobe.

- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- host_data  in  6  allophone code from the host.
- host_wr  in  1  write strobe; one code per cycle.
- flush  in  1  discard queue and abort the pending dispatch.
- host_full  out  1  queue full; writes while high are rejected.
- count  out  AW+1  number of queued codes, from 0 to DEPTH.
- overflow  out  1  sticky; set when a write is rejected.
- ldq  in  1  controller ready for the next allophone (level).
- data_out  out  6  code to controller `data_in`.
- data_stb  out  1  one-cycle load strobe to the controller.
- busy  out  1  high when the queue is non-empty or the FSM is not in IDLE.
- timeout  out  1  sticky; set when `ldq` does not drop within STB_TIMEOUT cycles.

## Operation

- FIFO
  - Write is accepted when `host_wr` is high, `host_full` is low and `flush` is low.
  - `host_full` is derived from registered `count` (high when `count` = DEPTH).
  - A write while full is rejected and sets `overflow`, even if a pop occurs in the same cycle.
  - A simultaneous push and pop on a non-full, non-empty queue leaves `count` unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, STROBE, WAIT_LOW.
  - IDLE: if `ldq`=1 and `count`≠0, pop the head into `data_out`, set `data_stb`=1 and go to STROBE.
  - STROBE: `data_stb` is low from the next cycle, clear the guard counter, go to WAIT_LOW.
  - WAIT_LOW: when `ldq`=0, go to IDLE. Otherwise increment the guard counter. When it reaches STB_TIMEOUT, set `timeout` and go to IDLE; the code counts as consumed.
- IDLE requires `ldq` to be observed high again before the next dispatch, so one controller load request yields exactly one strobe.
- `data_out` holds the last dispatched code until the next dispatch.
- `flush` (priority over `host_wr` and dispatch):
  - empties the FIFO and clears `overflow` and `timeout`;
  - forces IDLE and sets `data_stb`=0 next cycle;
  - leaves `data_out` unchanged.
- `rst` does everything `flush` does and also clears `data_out` and the guard counter.

## Timing

- Reset values: `data_out`=0, `data_stb`=0, `count`=0, `host_full`=0, `overflow`=0, `timeout`=0, `busy`=0, FSM=IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: a write accepted at edge N into an empty queue with `ldq` high gives `data_stb` high for exactly the cycle between edges N+2 and N+3. There is no fall-through.
- The pop and `count` decrement happen on the same edge that raises `data_stb`.
- Minimum spacing between strobes is 3 cycles (STROBE, WAIT_LOW, IDLE), plus however long `ldq` stays low.
- `rst` or `flush` asserted during STROBE: `data_stb` falls at the next edge, and the popped code is not re-queued.
- `ldq` already low in the STROBE cycle: WAIT_LOW exits on its first cycle.

## Structure

- Shared package `speech256_pkg` holds:
  - ALLO_W=6;
  - the FSM state encoding `aq_state_t`;
  - the pause codes PA1..PA5 = 0..4, which the queue passes through untouched.
- Sub-module `allo_fifo`:
  - parameters DEPTH and AW;
  - synchronous push/pop with registered `count`;
  - flush port.
- The FSM, guard counter and sticky flags live in `allophone_queue`.

## Test plan

- Reset, `ldq`=1, write 6 at cycle 10 → `data_stb` high only in cycle 12 with `data_out`=6, `count` returns to 0, `busy` falls once the FSM is back in IDLE.
- Write 6, 7, 8 back-to-back while `ldq`=0 → no strobe. Then pulse `ldq` low→high three times → strobes carry 6, 7, 8 in order, one strobe per rising `ldq`.
- Fill 8 entries with `ldq`=0 → `host_full`=1. A 9th write → rejected, `overflow`=1, `count`=8. Flush → `count`=0, `overflow`=0.
- After a strobe, hold `ldq`=1 → `timeout`=1 after 15 WAIT_LOW cycles, FSM returns to IDLE, and the next queued code dispatches.
- Assert `flush` in the same cycle as a dispatch and a `host_wr` → `data_stb` low the next cycle, `count`=0, the written code is dropped.
- Write codes cycling 0..63 while the controller model toggles `ldq` with random 1–20 cycle gaps, across at least 3 pointer wraps → the strobed sequence equals the written sequence.
